score_scanner: RTL
==================

# score_scanner

Scoreboard controller that owns the single shared 7-segment decoder in the pong display path. It converts two binary player scores (0–99) to decimal digits with a sequential subtract-by-ten engine, and commits all four digits to display registers atomically. It time-multiplexes the digits onto one `digit_value` bus with a one-hot digit select. A blanking window at each slot start and leading-zero suppression drive `blank`; the decoder's segment outputs are gated by `blank`.

## Interface
- `SCAN_DIV`, default 1024: clock cycles per digit slot; legal range ≥ 2.
- `BLANK`, default 16: blanked cycles at the start of every slot; legal range 0 ≤ BLANK < SCAN_DIV.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: single-cycle request to convert and display new scores.
- `score_a` in 7: player A score, unsigned binary.
- `score_b` in 7: player B score, unsigned binary.
- `busy` out 1: high while a conversion is in flight; `load` is ignored while high.
- `digit_value` out 4: decimal digit (0–9) for the current slot; feeds the shared decoder.
- `digit_sel` out 4: one-hot active-high digit enable; bit 0 is the leftmost digit.
- `blank` out 1: high means segments off and `digit_sel` = 0.

## Operation
- Converter FSM states: IDLE, CONV_A, CONV_B, COMMIT.
  - `busy` = 1 in every state except IDLE.
- IDLE:
  - If `load` = 1, capture both scores into working registers, saturating values > 99 to 99.
  - Clear the tens counter and go to CONV_A.
- CONV_A, once per cycle:
  - If rem ≥ 10: rem -= 10 and tens += 1.
  - Else: write tens/rem into shadow A digits, load the B working value, clear tens, go to CONV_B.
- CONV_B: identical to CONV_A using the B value, writing shadow B digits; exits to COMMIT.
- COMMIT: copy all four shadow digits into the display registers in the same cycle, then go to IDLE.
- `load` asserted in any non-IDLE state is dropped (no queueing).
- Arithmetic: working remainder is 7 bits, tens counter 4 bits; digits never exceed 9.
- Scanner:
  - Free-running counter 0..SCAN_DIV-1, independent of the converter.
  - On wrap, slot advances 0→1→2→3→0.
  - Slot map: 0 = A tens, 1 = A ones, 2 = B tens, 3 = B ones.
- Outputs are combinational from registered state (counter, slot, display registers):
  - `digit_value` = display digit of the current slot, always driven, including while blanked.
  - `blank` = 1 when counter < BLANK, or when the slot is 0 or 2 and that tens digit is 0 (leading-zero suppression).
  - `digit_sel` = one-hot(slot) when `blank` = 0, else 4'b0000.
- A display-register update may land mid-slot; the new digit appears on the next cycle, with no restart of the slot.

## Timing
- Reset state: FSM IDLE, `busy` 0, counter 0, slot 0, all display and shadow digits 0.
  - Resulting outputs: `digit_value` 0, `blank` 1, `digit_sel` 0.
- Reset during conversion aborts it: shadow data is discarded and the display reverts to zeros.
- `load` sampled high at edge E0:
  - `busy` = 1 after E0.
  - CONV_A occupies ta+1 cycles and CONV_B tb+1 cycles, where ta/tb are the tens digits.
  - COMMIT edge at E0+ta+tb+3 updates the display registers and drops `busy` at that same edge.
- Busy duration is ta+tb+3 cycles: minimum 3 (0/0), maximum 21 (99/99 or saturated inputs).
- A `load` in the same cycle that `busy` falls (state IDLE) is accepted.
- Slot period is exactly SCAN_DIV cycles; full refresh is 4·SCAN_DIV cycles.
- For a non-suppressed digit, `blank` = 1 for the first BLANK cycles of the slot.
- The slot index changes on the same edge the counter wraps to 0.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK=2.
- Reset, hold `load` low for 64 cycles: `digit_sel` stays 0 in slots 0 and 2 (leading zero); slots 1 and 3 show `digit_value` 0, with `digit_sel` 0010 / 1000 in counter 2..7 and 0 in counter 0..1.
- `load` with A=57, B=3: `busy` high exactly 3+5+0 = 8 cycles. Afterwards a refresh shows slot0=5, slot1=7, slot2 blanked, slot3=3.
- `load` with A=120, B=99: saturates, displays 99/99, `busy` high 21 cycles.
- Pulse `load` again 4 cycles into a conversion: ignored, and the original values are displayed. A `load` on the cycle `busy` falls starts a new conversion.
- Assert `reset` during CONV_B of an A=88, B=44 load: display stays 0/0 and `busy` = 0 on the next cycle.
- Apply the commit mid-slot: `digit_value` changes on the cycle after the COMMIT edge, and slot and counter phase are unaffected.

Source files
------------

// File: rtl/score_scanner.sv
// Scoreboard controller: converts two 0-99 scores to decimal digits with a
// subtract-by-ten engine and time-multiplexes four digits onto one decoder bus.
module score_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter int BLANK    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] score_a,
  input  logic [6:0] score_b,
  output logic       busy,
  output logic [3:0] digit_value,
  output logic [3:0] digit_sel,
  output logic       blank,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BLANK_C = (CW + 1)'(BLANK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_A = 2'd1,
    CONV_B = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [6:0] rem;
  logic [6:0] wb;
  logic [3:0] tens;
  // Digit order in both arrays matches the slot map: A tens, A ones, B tens, B ones.
  logic [3:0][3:0] shadow;
  logic [3:0][3:0] disp;

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic          tens_zero;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONV_A;
      CONV_A:  if (rem < 7'd10) state_nxt = CONV_B;
      CONV_B:  if (rem < 7'd10) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem    <= '0;
      wb     <= '0;
      tens   <= '0;
      shadow <= '0;
      disp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            rem  <= sat99(score_a);
            wb   <= sat99(score_b);
            tens <= '0;
          end
        end
        CONV_A, CONV_B: begin
          if (rem >= 7'd10) begin
            rem  <= rem - 7'd10;
            tens <= tens + 4'd1;
          end else begin
            // Remainder below ten is the ones digit; A hands over to B here.
            if (state == CONV_A) begin
              shadow[0] <= tens;
              shadow[1] <= rem[3:0];
              rem       <= wb;
            end else begin
              shadow[2] <= tens;
              shadow[3] <= rem[3:0];
            end
            tens <= '0;
          end
        end
        COMMIT:  disp <= shadow;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      slot <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign digit_value = disp[slot];
  assign tens_zero   = ((slot == 2'd0) || (slot == 2'd2)) && (disp[slot] == 4'd0);
  assign blank       = ({1'b0, cnt} < BLANK_C) || tens_zero;
  assign digit_sel   = blank ? 4'b0000 : (4'b0001 << slot);

endmodule
